rx_uc: RTL and testbench
========================

Name: rx_uc

Overview:
- Control unit for the UART receiver. It is the counterpart of the transmit control unit on the same serial link.
- It detects a start bit on the synchronised serial line, times the bit centres from a 16x oversampling tick, and issues control strobes to the receive datapath: clear, shift and done.
- It flags framing errors, and parity errors when the optional feature is compiled in.
- It contains no data register. The datapath shifts `rxd` on each `sample_en`.

Parameters:
- DATA_BITS, 8: data bits per frame, sent LSB first.
- OVERSAMPLE, 16: baud_tick pulses per bit period. Must be an even number, 4 or greater.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- baud_tick, input, 1: one-clk enable pulse at OVERSAMPLE x baud rate.
- rxd, input, 1: serial line, already synchronised. Idles high.
- reset_fd, output, 1: datapath clear strobe.
- sample_en, output, 1: datapath shift strobe. The datapath captures `rxd` on this edge.
- rx_done, output, 1: frame-received pulse.
- frame_err, output, 1: stop bit was low.
- parity_err, output, 1: parity mismatch. Tied to 0 without RX_PARITY_EN.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset: `rst`=1 at a clk edge forces state IDLE, tick_cnt=0 and bit_cnt=0, overriding all else, including mid-frame. While `rst` is high, all outputs are 0.
- Counter widths: tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS+1) bits. Counters change only on edges where baud_tick=1, except for the clears listed below.
- States: IDLE, START, DATA, [PARITY], STOP, DONE, FERR, BREAK.
- IDLE:
  - On baud_tick with rxd=0: go to START and clear both counters.
  - reset_fd=1 combinationally in that same cycle (baud_tick & !rxd in IDLE). It is 0 otherwise, including while the line is idle.
- START:
  - Increment tick_cnt on each baud_tick.
  - On the baud_tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rxd=0: go to DATA with tick_cnt=0.
    - rxd=1: false start; go to IDLE with no error flag.
- DATA:
  - Increment tick_cnt on each baud_tick.
  - On the baud_tick where tick_cnt==OVERSAMPLE-1: sample_en=1 for that one clk (Mealy), tick_cnt wraps to 0, bit_cnt increments.
  - After sample number DATA_BITS: go to PARITY if the feature is enabled, otherwise STOP.
  - Exactly DATA_BITS sample_en pulses per accepted frame.
- STOP:
  - Same timing as DATA: sample on the tick where tick_cnt==OVERSAMPLE-1. No sample_en is issued here.
  - rxd=1: go to DONE.
  - rxd=0: go to FERR.
- DONE: rx_done=1 for exactly one clk, independent of baud_tick. Then IDLE.
- FERR: frame_err=1 for exactly one clk. Then BREAK.
- BREAK:
  - Stay while the line is low.
  - On a baud_tick with rxd=1, go to IDLE. This prevents a held-low or break line from re-triggering a start.
- Back-to-back frames: a start edge on the first baud_tick after returning to IDLE must be accepted, so no idle gap is required beyond the stop bit.
- baud_tick=0: no state or counter change, except DONE and FERR, which exit unconditionally.
- Outputs are Moore from state, except reset_fd and sample_en, which are Mealy as defined above. No output glitches on non-tick cycles.

Optional Feature:
- Macro: RX_PARITY_EN.
- When defined:
  - Add a PARITY state after DATA with identical bit timing.
  - A parity accumulator is cleared on the IDLE to START transition and XORs in rxd at each DATA sample point.
  - At the PARITY sample point, mismatch is accumulator XOR rxd != 0 (even parity).
  - On mismatch, latch a flag. parity_err pulses for one clk in DONE, concurrent with rx_done. PARITY then proceeds to STOP.
  - A framing error takes precedence: the flag is discarded and parity_err stays 0.
- When not defined:
  - No PARITY state exists. DATA goes straight to STOP.
  - parity_err is constant 0.
  - Frame length is 1+DATA_BITS+1 bits.

Test Plan:
- Nominal frame: defaults, baud_tick every 4 clk, send 0xA5 LSB first with stop=1. Required: one reset_fd pulse, 8 sample_en pulses spaced 64 clk apart with rxd at each equal to 1,0,1,0,0,1,0,1, one rx_done pulse, frame_err=0, busy falls after DONE.
- False start: rxd low for 3 ticks, then high. Required: one reset_fd pulse, return to IDLE at tick 8, no sample_en, no rx_done or frame_err, busy=0 afterwards.
- Framing error and break: valid data with stop bit 0, line held low for 40 more ticks. Required: 8 sample_en, one frame_err pulse, no rx_done, busy=1 through BREAK, no new reset_fd until rxd returns to 1.
- Reset mid-frame: assert rst for 1 clk after the 3rd sample_en. Required: all outputs 0, busy=0. A following 0x3C frame is then received with exactly 8 sample_en and one rx_done.
- Back-to-back: 0x00 followed immediately by 0xFF with no idle gap. Required: 2 rx_done pulses, 16 sample_en, frame_err=0.
- RX_PARITY_EN defined: 0x07 with parity bit 1 gives rx_done and parity_err=0. The same data with parity bit 0 gives rx_done and parity_err both high in the same clk.

Source files
------------

// File: rtl/rx_uc.sv
// rx_uc: UART receive control unit.
// Detects a start bit, times bit centres from an oversampling tick and
// strobes the receive datapath (clear, shift, done). It also reports
// framing errors.
// Optional feature macro: RX_PARITY_EN adds an even-parity bit after the
// data bits and drives parity_err. Without it parity_err is tied to 0.
module rx_uc #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic rxd,
    output logic reset_fd,
    output logic sample_en,
    output logic rx_done,
    output logic frame_err,
    output logic parity_err,
    output logic busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE,
        FERR,
        BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bit_q, bit_d;
`ifdef RX_PARITY_EN
    logic          par_acc_q, par_acc_d;
    logic          par_flag_q, par_flag_d;
`endif

    // State and counter registers; a synchronous reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
`ifdef RX_PARITY_EN
            par_acc_q  <= 1'b0;
            par_flag_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
`ifdef RX_PARITY_EN
            par_acc_q  <= par_acc_d;
            par_flag_q <= par_flag_d;
`endif
        end
    end

    // Next state, counter updates and strobes; all outputs are held low during reset.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
`ifdef RX_PARITY_EN
        par_acc_d  = par_acc_q;
        par_flag_d = par_flag_q;
`endif
        reset_fd   = 1'b0;
        sample_en  = 1'b0;
        rx_done    = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        busy       = 1'b0;

        if (!rst) begin
            busy = (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (baud_tick && !rxd) begin
                        reset_fd   = 1'b1;
                        state_d    = START;
                        tick_d     = '0;
                        bit_d      = '0;
`ifdef RX_PARITY_EN
                        par_acc_d  = 1'b0;
                        par_flag_d = 1'b0;
`endif
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_q == TICK_HALF) begin
                            tick_d  = '0;
                            state_d = rxd ? IDLE : DATA;
                        end else begin
                            tick_d = tick_q + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (tick_q == TICK_LAST) begin
                            sample_en = 1'b1;
                            tick_d    = '0;
                            bit_d     = bit_q + BW'(1);
`ifdef RX_PARITY_EN
                            par_acc_d = par_acc_q ^ rxd;
                            if (bit_q == BIT_LAST) begin
                                state_d = PARITY;
                            end
`else
                            if (bit_q == BIT_LAST) begin
                                state_d = STOP;
                            end
`endif
                        end else begin
                            tick_d = tick_q + TW'(1);
                        end
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        if (tick_q == TICK_LAST) begin
                            tick_d     = '0;
                            par_flag_d = par_acc_q ^ rxd;
                            state_d    = STOP;
                        end else begin
                            tick_d = tick_q + TW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        if (tick_q == TICK_LAST) begin
                            tick_d  = '0;
                            state_d = rxd ? DONE : FERR;
                        end else begin
                            tick_d = tick_q + TW'(1);
                        end
                    end
                end
                DONE: begin
                    rx_done = 1'b1;
`ifdef RX_PARITY_EN
                    parity_err = par_flag_q;
`endif
                    state_d = IDLE;
                end
                FERR: begin
                    frame_err = 1'b1;
`ifdef RX_PARITY_EN
                    par_flag_d = 1'b0;
`endif
                    state_d = BREAK;
                end
                BREAK: begin
                    if (baud_tick && rxd) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_uc.sv
// tb_rx_uc: self-checking bench for rx_uc.
// The serial line is built as a list of per-tick levels. A frame-level
// reference model turns that list into the expected strobe events and the
// expected busy level at each tick. The DUT is then driven tick by tick,
// with baud_tick every 4 clocks, and its events are compared with the model.
module tb_rx_uc;

    localparam int OS   = 16;
    localparam int DB   = 8;
    localparam int HALF = OS / 2;
`ifdef RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic baud_tick;
    logic rxd;
    logic reset_fd;
    logic sample_en;
    logic rx_done;
    logic frame_err;
    logic parity_err;
    logic busy;

    int checks = 0;
    int errors = 0;

    bit line[$];
    bit rstq[$];
    bit busy_exp[$];
    int exp_ev[$];
    int obs_ev[$];

    rx_uc dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rxd       (rxd),
        .reset_fd  (reset_fd),
        .sample_en (sample_en),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Event code: tick index, kind (0 clear, 1 sample, 2 done, 3 ferr, 4 perr), sampled value.
    function automatic int enc(input int t, input int k, input bit v);
        return t * 16 + k * 2 + int'(v);
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic addIdle(input int n, input bit lvl);
        for (int i = 0; i < n; i++) begin
            line.push_back(lvl);
            rstq.push_back(1'b0);
        end
    endtask

    task automatic addFrame(input logic [7:0] data, input bit stop_bit, input bit par_ok);
        addIdle(OS, 1'b0);
        for (int k = 0; k < DB; k++) addIdle(OS, data[k]);
        if (P == 1) addIdle(OS, bit'((^data) ^ !par_ok));
        addIdle(OS, stop_bit);
    endtask

    // Frame-level reference: start edge, mid-start check, bit centres every OS ticks.
    task automatic buildModel();
        int n;
        int pos;
        n   = line.size();
        pos = 0;
        busy_exp = {};
        for (int i = 0; i < n; i++) busy_exp.push_back(1'b0);
        while (pos < n) begin
            int s;
            int mid;
            int e;
            int r;
            int st;
            bit par;
            int tmp[$];
            s = -1;
            for (int j = pos; j < n; j++) begin
                if (!rstq[j] && line[j] == 1'b0) begin
                    s = j;
                    break;
                end
            end
            if (s < 0) break;
            mid = s + HALF;
            st  = mid + OS * (DB + 1 + P);
            if (st >= n) break;
            tmp = {};
            tmp.push_back(enc(s, 0, 1'b0));
            if (line[mid] == 1'b1) begin
                e = mid;
            end else begin
                par = 1'b0;
                for (int k = 1; k <= DB; k++) begin
                    tmp.push_back(enc(mid + OS * k, 1, line[mid + OS * k]));
                    par ^= line[mid + OS * k];
                end
                if (P == 1) par ^= line[mid + OS * (DB + 1)];
                if (line[st] == 1'b1) begin
                    tmp.push_back(enc(st, 2, 1'b0));
                    if (P == 1 && par) tmp.push_back(enc(st, 4, 1'b0));
                    e = st;
                end else begin
                    int t;
                    tmp.push_back(enc(st, 3, 1'b0));
                    t = st + 1;
                    while (t < n && line[t] == 1'b0 && !rstq[t]) t++;
                    e = (t < n) ? t : n - 1;
                end
            end
            r = -1;
            for (int j = s + 1; j <= e; j++) begin
                if (rstq[j]) begin
                    r = j;
                    break;
                end
            end
            if (r >= 0) e = r;
            foreach (tmp[i]) begin
                if (r < 0 || (tmp[i] / 16) < r) exp_ev.push_back(tmp[i]);
            end
            for (int j = s + 1; j <= e; j++) begin
                if (!(r >= 0 && j == r)) busy_exp[j] = 1'b1;
            end
            pos = e + 1;
        end
    endtask

    // One tick window: the tick clock plus three quiet clocks, sampled 1 unit after the falling edge.
    task automatic applyStimulus(input int i);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rxd       = line[i];
            baud_tick = (c == 0);
            rst       = (c == 0) && rstq[i];
            #1;
            if (c == 0) checkOutput($sformatf("busy_t%0d", i), int'(busy), int'(busy_exp[i]));
            if (rst) begin
                checkOutput($sformatf("rst_outs_t%0d", i),
                            int'({reset_fd, sample_en, rx_done, frame_err, parity_err, busy}), 0);
            end
            if (reset_fd)   obs_ev.push_back(enc(i, 0, 1'b0));
            if (sample_en)  obs_ev.push_back(enc(i, 1, rxd));
            if (rx_done)    obs_ev.push_back(enc(i, 2, 1'b0));
            if (frame_err)  obs_ev.push_back(enc(i, 3, 1'b0));
            if (parity_err) obs_ev.push_back(enc(i, 4, 1'b0));
        end
    endtask

    // Directed scenarios, then randomized frames, then tick-by-tick run and event comparison.
    initial begin
        int s0;
        int n_exp;
        int n_obs;
        rst       = 1'b1;
        baud_tick = 1'b0;
        rxd       = 1'b1;

        addIdle(5, 1'b1);
        addFrame(8'hA5, 1'b1, 1'b1);
        addIdle(3, 1'b1);
        addIdle(3, 1'b0);
        addIdle(10, 1'b1);
        addFrame(8'h5A, 1'b0, 1'b1);
        addIdle(40, 1'b0);
        addIdle(5, 1'b1);
        s0 = line.size();
        addFrame(8'hFF, 1'b1, 1'b1);
        rstq[s0 + HALF + 3 * OS + 4] = 1'b1;
        addIdle(4, 1'b1);
        addFrame(8'h3C, 1'b1, 1'b1);
        addIdle(2, 1'b1);
        addFrame(8'h00, 1'b1, 1'b1);
        addFrame(8'hFF, 1'b1, 1'b1);
        addIdle(3, 1'b1);
        if (P == 1) begin
            addFrame(8'h07, 1'b1, 1'b1);
            addIdle(2, 1'b1);
            addFrame(8'h07, 1'b1, 1'b0);
            addIdle(2, 1'b1);
        end
        for (int f = 0; f < 8; f++) begin
            bit stop_bit;
            stop_bit = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                addIdle($urandom_range(1, HALF - 1), 1'b0);
                addIdle($urandom_range(1, 6), 1'b1);
            end
            addFrame(8'($urandom_range(0, 255)), stop_bit, bit'($urandom_range(0, 1)));
            if (!stop_bit) addIdle($urandom_range(0, 20), 1'b0);
            addIdle($urandom_range(0, 3), 1'b1);
        end
        addIdle(20, 1'b1);

        buildModel();
        $display("[TB] ticks=%0d expected_events=%0d", line.size(), exp_ev.size());

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checkOutput("reset_outs", int'({reset_fd, sample_en, rx_done, frame_err, parity_err, busy}), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_busy", int'(busy), 0);

        for (int i = 0; i < line.size(); i++) applyStimulus(i);

        checkOutput("event_count", obs_ev.size(), exp_ev.size());
        n_exp = exp_ev.size();
        n_obs = obs_ev.size();
        for (int i = 0; i < ((n_exp < n_obs) ? n_exp : n_obs); i++) begin
            checkOutput($sformatf("event%0d", i), obs_ev[i], exp_ev[i]);
        end
        checkOutput("final_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
